// File: rtl/duck_flight.sv
// duck_flight: per-duck flight, shot and escape engine.
//
// Takes the control FSM's release_bird request and the player's trigger/aim.
// It moves one duck once per video frame, detects hits on the system clock,
// and reports shot / bird_shot / flew_away pulses back to the control FSM.
//
// Ports:
//   CLK           system clock (only clock)
//   RESET_N       synchronous, active-low reset
//   frame_tick    one-cycle pulse per video frame
//   release_bird  spawn request (honoured only in IDLE)
//   trigger       synchronised level trigger
//   aim_x, aim_y  crosshair position
//   duck_x/y      duck top-left position (registered)
//   duck_visible  duck on screen (registered)
//   duck_state    IDLE=0, FLY=1 (also ESCAPE), HIT=2, FALL=3 (registered)
//   shot          one-cycle pulse per trigger press counted in FLY
//   bird_shot     one-cycle hit pulse
//   flew_away     one-cycle escape-complete pulse
module duck_flight #(
    parameter int SCREEN_W   = 640,
    parameter int GROUND_Y   = 400,
    parameter int DUCK_SIZE  = 32,
    parameter int SPEED      = 2,
    parameter int START_X    = 304,
    parameter int FLY_FRAMES = 300,
    parameter int HIT_FRAMES = 30,
    parameter int MAX_SHOTS  = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       frame_tick,
    input  logic       release_bird,
    input  logic       trigger,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    output logic [9:0] duck_x,
    output logic [9:0] duck_y,
    output logic       duck_visible,
    output logic [1:0] duck_state,
    output logic       shot,
    output logic       bird_shot,
    output logic       flew_away
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FLY    = 3'd1;
    localparam logic [2:0] ST_HIT    = 3'd2;
    localparam logic [2:0] ST_FALL   = 3'd3;
    localparam logic [2:0] ST_ESCAPE = 3'd4;

    localparam int FLY_W  = $clog2(FLY_FRAMES + 1);
    localparam int HOLD_W = $clog2(HIT_FRAMES + 1);
    localparam int SHOT_W = $clog2(MAX_SHOTS + 1);

    // Motion math runs in 11-bit signed so a step below zero is visible.
    localparam logic signed [10:0] X_MAX_S = 11'(SCREEN_W - DUCK_SIZE);
    localparam logic signed [10:0] Y_MAX_S = 11'(GROUND_Y - DUCK_SIZE);
    localparam logic signed [10:0] STEP_S  = 11'(SPEED);
    localparam logic [10:0]        Y_MAX_U = 11'(GROUND_Y - DUCK_SIZE);
    localparam logic [10:0]        VSTEP_U = 11'(2 * SPEED);
    localparam logic [10:0]        SIZE_U  = 11'(DUCK_SIZE);
    localparam logic [9:0]         SPAWN_X = 10'(START_X);
    localparam logic [9:0]         SPAWN_Y = 10'(GROUND_Y - DUCK_SIZE);

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              dir_x_q, dir_x_d;      // 1 = moving right
    logic              dir_up_q, dir_up_d;    // 1 = moving up (y decreasing)
    logic [FLY_W-1:0]  fly_cnt_q, fly_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SHOT_W-1:0] shot_cnt_q, shot_cnt_d;
    logic              trig_q, trig_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [1:0]        duck_state_q, duck_state_d;
    logic              visible_q, visible_d;
    logic              shot_q, shot_d, bird_shot_q, bird_shot_d, flew_away_q, flew_away_d;

    logic                edge_s, hit_s, shot_limit_s, fly_last_s;
    logic [SHOT_W-1:0]   shot_inc_s;
    logic [FLY_W-1:0]    fly_inc_s;
    logic [HOLD_W-1:0]   hold_inc_s;
    logic signed [10:0]  nx_s, ny_s;
    logic [9:0]          mv_x_s, mv_y_s;
    logic                mv_dir_x_s, mv_dir_up_s;
    logic [10:0]         fall_y_s;

    // Trigger edge, hit test on the current position and saturating counters.
    always_comb begin
        edge_s       = trigger & ~trig_q;
        hit_s        = ({1'b0, aim_x} >= {1'b0, x_q}) && ({1'b0, aim_x} < ({1'b0, x_q} + SIZE_U)) &&
                       ({1'b0, aim_y} >= {1'b0, y_q}) && ({1'b0, aim_y} < ({1'b0, y_q} + SIZE_U));
        shot_inc_s   = (shot_cnt_q == {SHOT_W{1'b1}}) ? shot_cnt_q : shot_cnt_q + SHOT_W'(1);
        fly_inc_s    = (fly_cnt_q == {FLY_W{1'b1}}) ? fly_cnt_q : fly_cnt_q + FLY_W'(1);
        hold_inc_s   = (hold_cnt_q == {HOLD_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        shot_limit_s = (shot_inc_s == SHOT_W'(MAX_SHOTS));
        fly_last_s   = (fly_cnt_q == FLY_W'(FLY_FRAMES - 1));
        fall_y_s     = {1'b0, y_q} + VSTEP_U;
    end

    // One FLY step with bounce: clamp to the playfield edge and reverse.
    always_comb begin
        nx_s = dir_x_q  ? $signed({1'b0, x_q}) + STEP_S : $signed({1'b0, x_q}) - STEP_S;
        ny_s = dir_up_q ? $signed({1'b0, y_q}) - STEP_S : $signed({1'b0, y_q}) + STEP_S;
        if (nx_s < 11'sd0) begin
            mv_x_s = 10'd0;
            mv_dir_x_s = ~dir_x_q;
        end else if (nx_s > X_MAX_S) begin
            mv_x_s = X_MAX_S[9:0];
            mv_dir_x_s = ~dir_x_q;
        end else begin
            mv_x_s = nx_s[9:0];
            mv_dir_x_s = dir_x_q;
        end
        if (ny_s < 11'sd0) begin
            mv_y_s = 10'd0;
            mv_dir_up_s = ~dir_up_q;
        end else if (ny_s > Y_MAX_S) begin
            mv_y_s = Y_MAX_S[9:0];
            mv_dir_up_s = ~dir_up_q;
        end else begin
            mv_y_s = ny_s[9:0];
            mv_dir_up_s = dir_up_q;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_up_d    = dir_up_q;
        fly_cnt_d   = fly_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        shot_cnt_d  = shot_cnt_q;
        trig_d      = trigger;
        lfsr_d      = lfsr_next(lfsr_q);
        shot_d      = 1'b0;
        bird_shot_d = 1'b0;
        flew_away_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (release_bird) begin
                    state_d    = ST_FLY;
                    x_d        = SPAWN_X;
                    y_d        = SPAWN_Y;
                    dir_x_d    = lfsr_q[0];
                    dir_up_d   = 1'b1;
                    shot_cnt_d = {SHOT_W{1'b0}};
                    fly_cnt_d  = {FLY_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLY: begin
                shot_d = edge_s;
                // Hit beats shot-limit beats timeout; any exit freezes the duck this cycle.
                if (edge_s && hit_s) begin
                    bird_shot_d = 1'b1;
                    state_d     = ST_HIT;
                    hold_cnt_d  = {HOLD_W{1'b0}};
                end else if (edge_s && shot_limit_s) begin
                    shot_cnt_d = shot_inc_s;
                    state_d    = ST_ESCAPE;
                end else if (frame_tick && fly_last_s) begin
                    state_d = ST_ESCAPE;
                end else begin
                    shot_cnt_d = edge_s ? shot_inc_s : shot_cnt_q;
                    if (frame_tick) begin
                        x_d       = mv_x_s;
                        y_d       = mv_y_s;
                        dir_x_d   = mv_dir_x_s;
                        dir_up_d  = mv_dir_up_s;
                        fly_cnt_d = fly_inc_s;
                    end else begin
                        fly_cnt_d = fly_cnt_q;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick && (hold_cnt_q == HOLD_W'(HIT_FRAMES - 1))) begin
                    state_d = ST_FALL;
                end else if (frame_tick) begin
                    hold_cnt_d = hold_inc_s;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            ST_FALL: begin
                if (frame_tick && (fall_y_s >= Y_MAX_U)) begin
                    y_d     = SPAWN_Y;
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    y_d = fall_y_s[9:0];
                end else begin
                    y_d = y_q;
                end
            end
            ST_ESCAPE: begin
                if (frame_tick && ({1'b0, y_q} <= VSTEP_U)) begin
                    state_d     = ST_IDLE;
                    flew_away_d = 1'b1;
                end else if (frame_tick) begin
                    y_d = y_q - VSTEP_U[9:0];
                end else begin
                    y_d = y_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ESCAPE deliberately reports the FLY code to the renderer.
        case (state_d)
            ST_IDLE:   duck_state_d = 2'd0;
            ST_FLY:    duck_state_d = 2'd1;
            ST_HIT:    duck_state_d = 2'd2;
            ST_FALL:   duck_state_d = 2'd3;
            ST_ESCAPE: duck_state_d = 2'd1;
            default:   duck_state_d = 2'd0;
        endcase
        visible_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            x_q          <= SPAWN_X;
            y_q          <= SPAWN_Y;
            dir_x_q      <= 1'b0;
            dir_up_q     <= 1'b1;
            fly_cnt_q    <= {FLY_W{1'b0}};
            hold_cnt_q   <= {HOLD_W{1'b0}};
            shot_cnt_q   <= {SHOT_W{1'b0}};
            trig_q       <= 1'b0;
            lfsr_q       <= 8'hA5;
            duck_state_q <= 2'd0;
            visible_q    <= 1'b0;
            shot_q       <= 1'b0;
            bird_shot_q  <= 1'b0;
            flew_away_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_x_q      <= dir_x_d;
            dir_up_q     <= dir_up_d;
            fly_cnt_q    <= fly_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            shot_cnt_q   <= shot_cnt_d;
            trig_q       <= trig_d;
            lfsr_q       <= lfsr_d;
            duck_state_q <= duck_state_d;
            visible_q    <= visible_d;
            shot_q       <= shot_d;
            bird_shot_q  <= bird_shot_d;
            flew_away_q  <= flew_away_d;
        end
    end

    assign duck_x       = x_q;
    assign duck_y       = y_q;
    assign duck_visible = visible_q;
    assign duck_state   = duck_state_q;
    assign shot         = shot_q;
    assign bird_shot    = bird_shot_q;
    assign flew_away    = flew_away_q;

endmodule

// File: tb/tb_duck_flight.sv
// Self-checking bench for duck_flight: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the duck's game rules.
module tb_duck_flight;

    localparam int XMAX = 608;   // SCREEN_W - DUCK_SIZE
    localparam int YMAX = 368;   // GROUND_Y - DUCK_SIZE

    logic       CLK = 1'b0;
    logic       RESET_N, frame_tick, release_bird, trigger;
    logic [9:0] aim_x, aim_y, duck_x, duck_y;
    logic       duck_visible, shot, bird_shot, flew_away;
    logic [1:0] duck_state;

    duck_flight dut (
        .CLK(CLK), .RESET_N(RESET_N), .frame_tick(frame_tick), .release_bird(release_bird),
        .trigger(trigger), .aim_x(aim_x), .aim_y(aim_y), .duck_x(duck_x), .duck_y(duck_y),
        .duck_visible(duck_visible), .duck_state(duck_state), .shot(shot),
        .bird_shot(bird_shot), .flew_away(flew_away)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 fly, 2 hit, 3 fall, 4 escape
    int       m_state, m_x, m_y, m_dx, m_dy, m_fly, m_shots, m_hold;
    bit       m_trig, m_shot, m_hit, m_flew;
    int       m_lfsr;
    int       cnt_shot = 0, cnt_hit = 0, cnt_flew = 0, max_x = 0;
    bit       vis_at_flew = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e;
        bit in_box;
        int nx, ny, p;
        if (!RESET_N) begin
            m_state = 0; m_x = 304; m_y = YMAX; m_trig = 0; m_lfsr = 8'hA5;
            m_shot = 0; m_hit = 0; m_flew = 0;
            return;
        end
        e = trigger && !m_trig;
        in_box = (aim_x >= m_x) && (aim_x < m_x + 32) && (aim_y >= m_y) && (aim_y < m_y + 32);
        m_shot = 0; m_hit = 0; m_flew = 0;
        case (m_state)
            0: if (release_bird) begin
                m_state = 1; m_x = 304; m_y = YMAX;
                m_dx = (m_lfsr % 2 == 1) ? 1 : -1; m_dy = -1; m_fly = 0; m_shots = 0;
            end
            1: begin
                m_shot = e;
                if (e && in_box) begin
                    m_hit = 1; m_state = 2; m_hold = 0;
                end else if (e && m_shots + 1 >= 3) begin
                    m_state = 4;
                end else if (frame_tick && m_fly == 299) begin
                    m_state = 4;
                end else begin
                    if (e) m_shots++;
                    if (frame_tick) begin
                        nx = m_x + 2 * m_dx;
                        ny = m_y + 2 * m_dy;
                        if (nx < 0) begin nx = 0; m_dx = -m_dx; end
                        else if (nx > XMAX) begin nx = XMAX; m_dx = -m_dx; end
                        if (ny < 0) begin ny = 0; m_dy = -m_dy; end
                        else if (ny > YMAX) begin ny = YMAX; m_dy = -m_dy; end
                        m_x = nx; m_y = ny; m_fly++;
                    end
                end
            end
            2: if (frame_tick) begin
                m_hold++;
                if (m_hold == 30) m_state = 3;
            end
            3: if (frame_tick) begin
                if (m_y + 4 >= YMAX) begin m_y = YMAX; m_state = 0; end
                else m_y = m_y + 4;
            end
            default: if (frame_tick) begin
                if (m_y <= 4) begin m_state = 0; m_flew = 1; end
                else m_y = m_y - 4;
            end
        endcase
        m_trig = trigger;
        // taps 8,6,5,4 -> register bits 7,5,4,3; feedback parity enters at bit 0
        p = ((m_lfsr >> 7) + (m_lfsr >> 5) + (m_lfsr >> 4) + (m_lfsr >> 3)) % 2;
        m_lfsr = ((m_lfsr * 2) + p) % 256;
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        check_eq("duck_state", duck_state, (m_state == 4) ? 1 : m_state);
        check_eq("duck_visible", duck_visible, (m_state != 0) ? 1 : 0);
        check_eq("duck_x", duck_x, m_x);
        check_eq("duck_y", duck_y, m_y);
        check_eq("shot", shot, m_shot);
        check_eq("bird_shot", bird_shot, m_hit);
        check_eq("flew_away", flew_away, m_flew);
        cnt_shot += shot;
        cnt_hit  += bird_shot;
        cnt_flew += flew_away;
        if (flew_away && duck_visible) vis_at_flew = 1'b1;
        if (duck_x > max_x) max_x = duck_x;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            cyc(); cyc(); cyc();
        end
    endtask

    task automatic spawn();
        release_bird = 1'b1; cyc(); release_bird = 1'b0;
    endtask

    // Tick until the DUT hides the duck, bounded.
    task automatic wait_gone(input string tag, input int budget);
        int n = 0;
        while (duck_visible && n < budget) begin
            ticks(1);
            n++;
        end
        check_eq({tag, "_gone_in_budget"}, (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        int f0, s0, h0, px;
        RESET_N = 1'b0; frame_tick = 1'b0; release_bird = 1'b0; trigger = 1'b0;
        aim_x = 10'd0; aim_y = 10'd0;
        cyc(); cyc();
        check_eq("reset_state", duck_state, 0);
        check_eq("reset_visible", duck_visible, 0);
        check_eq("reset_xy", {duck_x, duck_y}, {10'd304, 10'd368});
        check_eq("reset_pulses", {shot, bird_shot, flew_away}, 0);
        RESET_N = 1'b1;
        cyc();

        // Spawn and first step
        spawn();
        check_eq("spawn_state", duck_state, 1);
        check_eq("spawn_visible", duck_visible, 1);
        check_eq("spawn_xy", {duck_x, duck_y}, {10'd304, 10'd368});
        ticks(1);
        check_eq("first_step_y", duck_y, 366);

        // Hit, freeze, fall; release_bird during FALL is ignored
        ticks(20);
        aim_x = 10'(m_x + 5); aim_y = 10'(m_y + 5);
        trigger = 1'b1; cyc(); trigger = 1'b0;
        check_eq("hit_shot", shot, 1);
        check_eq("hit_bird_shot", bird_shot, 1);
        check_eq("hit_state", duck_state, 2);
        ticks(30);
        release_bird = 1'b1; cyc(); release_bird = 1'b0;
        check_eq("fall_ignores_release", duck_state, 3);
        f0 = cnt_flew;
        wait_gone("hit", 40);
        check_eq("landed_y", duck_y, 368);
        check_eq("hit_no_flew", cnt_flew - f0, 0);

        // Three misses force an escape
        spawn();
        aim_x = 10'd0; aim_y = 10'd479;
        s0 = cnt_shot; h0 = cnt_hit; f0 = cnt_flew;
        repeat (3) begin
            trigger = 1'b1; cyc(); trigger = 1'b0; cyc();
        end
        check_eq("miss_shots", cnt_shot - s0, 3);
        check_eq("miss_no_hit", cnt_hit - h0, 0);
        wait_gone("miss", 200);
        check_eq("miss_flew_once", cnt_flew - f0, 1);
        check_eq("invisible_at_flew", vis_at_flew, 0);

        // Timeout while heading right: bounce at 608, then escape
        for (int i = 0; i < 40 && (m_lfsr % 2 == 0); i++) cyc();
        spawn();
        max_x = 0; f0 = cnt_flew;
        wait_gone("timeout", 500);
        check_eq("bounce_clamp_x", max_x, 608);
        check_eq("timeout_flew_once", cnt_flew - f0, 1);

        // Hit on the same cycle as the timeout tick wins
        spawn();
        ticks(299);
        px = m_x;
        aim_x = 10'(m_x + 5); aim_y = 10'(m_y + 5);
        trigger = 1'b1; frame_tick = 1'b1; cyc(); trigger = 1'b0; frame_tick = 1'b0;
        check_eq("coinc_bird_shot", bird_shot, 1);
        check_eq("coinc_state", duck_state, 2);
        check_eq("coinc_frozen_x", duck_x, px);
        f0 = cnt_flew;
        wait_gone("coinc", 200);
        check_eq("coinc_no_flew", cnt_flew - f0, 0);

        // Reset mid-flight with trigger held high
        spawn();
        ticks(5);
        s0 = cnt_shot; h0 = cnt_hit; f0 = cnt_flew;
        RESET_N = 1'b0; trigger = 1'b1;
        cyc(); cyc();
        check_eq("midreset_state", duck_state, 0);
        RESET_N = 1'b1;
        repeat (4) cyc();
        spawn();
        ticks(5);
        check_eq("midreset_no_pulses", (cnt_shot - s0) + (cnt_hit - h0) + (cnt_flew - f0), 0);
        trigger = 1'b0;
        cyc();

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            RESET_N      = ($urandom_range(0, 599) != 0);
            frame_tick   = ($urandom_range(0, 3) == 0);
            release_bird = ($urandom_range(0, 15) == 0);
            trigger      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                px = m_x + int'($urandom_range(0, 40)) - 4;
                aim_x = 10'((px < 0) ? 0 : px);
                px = m_y + int'($urandom_range(0, 40)) - 4;
                aim_y = 10'((px < 0) ? 0 : px);
            end else begin
                aim_x = 10'($urandom_range(0, 639));
                aim_y = 10'($urandom_range(0, 479));
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/duck_flight.md
# duck_flight

Per-duck flight, shot and escape engine that sits directly upstream of the game control FSM. It consumes the control FSM's `release_bird` pulse and produces the per-shot, hit and escape pulses that the FSM uses to score and count get-aways. It also drives the duck position and visibility consumed by the sprite renderer. Motion advances once per video frame; hit detection is cycle-accurate on the system clock.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `GROUND_Y`, 400: top of the grass line; the duck's lowest allowed top-left y is `GROUND_Y-DUCK_SIZE`.
- `DUCK_SIZE`, 32: square duck hitbox side.
- `SPEED`, 2: pixels per frame on each axis in FLY.
- `START_X`, 304: spawn x.
- `FLY_FRAMES`, 300: frames in FLY before a forced escape.
- `HIT_FRAMES`, 30: freeze frames after a hit.
- `MAX_SHOTS`, 3: misses that force an escape.

Ports:
- `CLK` in 1: system clock; the only clock.
- `RESET_N` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (vsync-derived).
- `release_bird` in 1: spawn request from the control FSM.
- `trigger` in 1: level trigger (light gun / mouse button), already synchronised.
- `aim_x`, `aim_y` in 10 each: crosshair position.
- `duck_x`, `duck_y` out 10 each: duck top-left position.
- `duck_visible` out 1: duck is on screen.
- `duck_state` out 2: IDLE=0, FLY=1, HIT=2, FALL=3. ESCAPE also reports 1.
- `shot` out 1: one-cycle pulse for each trigger press counted in FLY.
- `bird_shot` out 1: one-cycle hit pulse.
- `flew_away` out 1: one-cycle escape-complete pulse.

## Operation
- **States:** IDLE, FLY, HIT, FALL, ESCAPE.
- **Trigger edge:** `trig_q` holds `trigger` registered. A rising edge (`edge`) is `trigger & ~trig_q`.
- **Direction LFSR:** 8-bit free-running LFSR, polynomial x^8+x^6+x^5+x^4+1. Reset seed is 8'hA5. It steps every CLK.
- **IDLE:** on `release_bird`, go to FLY and load the spawn values:
  - `duck_x=START_X`, `duck_y=GROUND_Y-DUCK_SIZE`;
  - `dir_x = lfsr[0]` (1 = right), `dir_y` = up;
  - `shot_cnt=0`, `fly_cnt=0`.
  
  `release_bird` in any other state is ignored.
- **FLY, on `frame_tick`:**
  - Step x and y by ±SPEED.
  - Bounce: if the next x is <0 or >`SCREEN_W-DUCK_SIZE`, clamp x to that bound and invert `dir_x`. Apply the same rule to y against 0 and `GROUND_Y-DUCK_SIZE`.
  - Increment `fly_cnt`.
- **FLY, on `edge`:**
  - Pulse `shot`.
  - Hit test uses the current (pre-update) position: `duck_x <= aim_x < duck_x+DUCK_SIZE` and likewise for y.
  - Hit: pulse `bird_shot` and go to HIT with `hold_cnt=0`.
  - Miss: `shot_cnt++`. If it reaches MAX_SHOTS, go to ESCAPE.
- **FLY timeout:** on a `frame_tick` with `fly_cnt==FLY_FRAMES-1` and no hit or forced escape in the same cycle, go to ESCAPE.
- **Priority when events coincide:** hit > shot-limit escape > timeout. A coincident `frame_tick` does not move the duck in the transition cycle.
- **HIT:** position frozen. Count `frame_tick`. After HIT_FRAMES ticks, go to FALL.
- **FALL:** `duck_y += 2*SPEED` per tick. When the result would be ≥`GROUND_Y-DUCK_SIZE`, go to IDLE with no pulse.
- **ESCAPE:** x frozen; `duck_y -= 2*SPEED` per tick. When `duck_y <= 2*SPEED` at a tick, go to IDLE and pulse `flew_away`.
- **Edges outside FLY:** ignored; no `shot` pulse.
- **Arithmetic:** next positions are computed in 11-bit signed to detect underflow. All counters saturate rather than wrap.
- **`duck_visible`:** high in FLY, HIT, FALL and ESCAPE; 0 in IDLE.

## Timing
- **Registered outputs:** all outputs are registered. A pulse output is high for exactly one cycle.
- **Reset:** `RESET_N` low at a CLK edge gives, on the next cycle:
  - state IDLE, `duck_state=0`, `duck_visible=0`;
  - `duck_x=START_X`, `duck_y=GROUND_Y-DUCK_SIZE`;
  - `shot`, `bird_shot`, `flew_away` = 0;
  - `trig_q=0`, LFSR=8'hA5.
  
  Reset mid-flight aborts with no pulses. `trigger` held high through reset release produces no edge.
- **`release_bird` sampled in cycle N:** FLY and the spawn position appear at N+1.
- **`edge` in cycle N:** `shot` (and `bird_shot` on a hit) is high at N+1, and the new state is visible at N+1.
- **`frame_tick` in cycle N:** the position update is visible at N+1.
- **Escape completion:** `flew_away` is high in the same cycle that state returns to IDLE.
- **Back-to-back edges:** an edge needs `trigger` low for at least one cycle in between. No re-arming logic beyond this.

## Test plan
- **Spawn:** reset, then `release_bird` → next cycle `duck_state=1`, `duck_visible=1`, (304,368). After 1 tick, y=366 and x=306 or 302 matching `lfsr[0]`.
- **Hit:** aim at (duck_x+5, duck_y+5), trigger rising → `shot` and `bird_shot` high for one cycle. Then HIT for 30 ticks, then FALL, then IDLE with `duck_y=368` and no `flew_away`.
- **Three misses:** aim at (0,479) and press 3 times → 3 `shot` pulses and no `bird_shot`; ESCAPE after the third. `flew_away` pulses once when y≤4 at a tick; `duck_visible` is 0 the same cycle.
- **Timeout:** no trigger for 300 ticks → ESCAPE entered on tick 300, then `flew_away`.
- **Bounce and coincidence:** force x near 608 moving right → clamps to 608 and reverses. A hit edge coincident with the timeout tick → `bird_shot`, not escape.
- **Reset mid-FLY and ignored inputs:** reset mid-FLY with `trigger` held high → IDLE, no pulses, no `shot` after release. `release_bird` during FALL is ignored.
